// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 5-8 data bits, optional parity, 1/1.5/2 stop bits.
// Optional build macro UART_TX_PARITY_INJECT_EN adds inject_parity_err for forced parity errors.
//
// state      | meaning
// IDLE       | line high, tx_ready may assert
// START_BIT  | line low for one bit period
// DATA_BITS  | N data bits shifted out from the latched character
// PARITY_BIT | parity bit (only when latched parity_en is set)
// STOP_BIT   | line high for 1, 1.5 or 2 bit periods
module uart_tx_serializer #(
  parameter int CHAR_LENGTH    = 8,
  parameter int BAUD_DIV_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BAUD_DIV_WIDTH-1:0] cfg_baud_div,
  input  logic [3:0]                cfg_oversampling,
  input  logic [3:0]                cfg_uart_type,
  input  logic [1:0]                cfg_stop_bit,
  input  logic                      cfg_msb_first,
  input  logic                      cfg_parity_en,
  input  logic                      cfg_parity_type,
  input  logic [CHAR_LENGTH-1:0]    tx_data,
  input  logic                      tx_valid,
`ifdef UART_TX_PARITY_INJECT_EN
  input  logic                      inject_parity_err,
`endif
  output logic                      tx_ready,
  output logic                      tx,
  output logic                      busy,
  output logic [3:0]                fsm_state
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    START_BIT  = 4'd1,
    DATA_BITS  = 4'd2,
    PARITY_BIT = 4'd3,
    STOP_BIT   = 4'd4
  } state_t;

  localparam logic [BAUD_DIV_WIDTH-1:0] DIV_ONE = BAUD_DIV_WIDTH'(1);

  state_t                    state;
  logic [BAUD_DIV_WIDTH-1:0] div_q;
  logic [4:0]                os_q;
  logic [1:0]                stop_q;
  logic                      parity_en_q;
  logic                      parity_q;
  logic [CHAR_LENGTH-1:0]    shift_q;
  logic [3:0]                n_q;
  logic [3:0]                bit_cnt;
  logic [BAUD_DIV_WIDTH-1:0] baud_cnt;
  logic [4:0]                tick_cnt;

  logic                      type_ok;
  logic                      accept;
  logic [BAUD_DIV_WIDTH-1:0] div_eff;
  logic [4:0]                os_eff;
  logic [CHAR_LENGTH-1:0]    data_mask;
  logic [CHAR_LENGTH-1:0]    data_rev;
  logic [CHAR_LENGTH-1:0]    data_ordered;
  logic [3:0]                rev_shift;
  logic                      parity_bit;
  logic [4:0]                stop_ticks;

  assign type_ok   = (cfg_uart_type >= 4'd5) && (cfg_uart_type <= 4'd8);
  assign tx_ready  = (state == IDLE) && !reset && type_ok;
  assign accept    = tx_valid && tx_ready;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // Character is pre-ordered at acceptance so the datapath always shifts out bit 0 first.
  always_comb begin
    div_eff   = (cfg_baud_div == '0) ? DIV_ONE : cfg_baud_div;
    os_eff    = (cfg_oversampling == 4'd0) ? 5'd2 : {1'b0, cfg_oversampling};
    data_mask = ~({CHAR_LENGTH{1'b1}} << cfg_uart_type);
    data_rev  = '0;
    for (int i = 0; i < CHAR_LENGTH; i++) begin
      data_rev[i] = tx_data[CHAR_LENGTH-1-i];
    end
    rev_shift    = 4'(CHAR_LENGTH) - cfg_uart_type;
    data_ordered = (cfg_msb_first ? (data_rev >> rev_shift) : tx_data) & data_mask;
    parity_bit   = (^(tx_data & data_mask)) ^ cfg_parity_type;
`ifdef UART_TX_PARITY_INJECT_EN
    parity_bit   = parity_bit ^ inject_parity_err;
`endif
  end

  always_comb begin
    case (stop_q)
      2'd0:    stop_ticks = os_q + (os_q >> 1);
      2'd2:    stop_ticks = os_q << 1;
      default: stop_ticks = os_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx          <= 1'b1;
      div_q       <= '0;
      os_q        <= '0;
      stop_q      <= '0;
      parity_en_q <= 1'b0;
      parity_q    <= 1'b0;
      shift_q     <= '0;
      n_q         <= '0;
      bit_cnt     <= '0;
      baud_cnt    <= '0;
      tick_cnt    <= '0;
    end else if (state == IDLE) begin
      tx <= 1'b1;
      if (accept) begin
        div_q       <= div_eff;
        os_q        <= os_eff;
        stop_q      <= cfg_stop_bit;
        parity_en_q <= cfg_parity_en;
        parity_q    <= parity_bit;
        shift_q     <= data_ordered;
        n_q         <= cfg_uart_type;
        bit_cnt     <= '0;
        baud_cnt    <= div_eff - DIV_ONE;
        tick_cnt    <= os_eff - 5'd1;
        state       <= START_BIT;
        tx          <= 1'b0;
      end
    end else if (baud_cnt != '0) begin
      baud_cnt <= baud_cnt - DIV_ONE;
    end else if (tick_cnt != 5'd0) begin
      baud_cnt <= div_q - DIV_ONE;
      tick_cnt <= tick_cnt - 5'd1;
    end else begin
      // Terminal count of the current bit period: advance to the next bit.
      baud_cnt <= div_q - DIV_ONE;
      tick_cnt <= os_q - 5'd1;
      case (state)
        START_BIT: begin
          state   <= DATA_BITS;
          tx      <= shift_q[0];
          shift_q <= shift_q >> 1;
          bit_cnt <= 4'd1;
        end
        DATA_BITS: begin
          if (bit_cnt == n_q) begin
            if (parity_en_q) begin
              state <= PARITY_BIT;
              tx    <= parity_q;
            end else begin
              state    <= STOP_BIT;
              tx       <= 1'b1;
              tick_cnt <= stop_ticks - 5'd1;
            end
          end else begin
            tx      <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        PARITY_BIT: begin
          state    <= STOP_BIT;
          tx       <= 1'b1;
          tick_cnt <= stop_ticks - 5'd1;
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
